// File: rtl/wordboard_rx_if.sv
// Bus bundle for the wordboard serial receiver: line input, character and word
// outputs, and the word buffer read port. The receiver uses master; the consumer uses slave.
interface wordboard_rx_if;
   logic       rx;
   logic       char_valid;
   logic [7:0] char_data;
   logic       frame_err;
   logic       word_done;
   logic [5:0] word_len;
   logic       busy;
   logic [5:0] rd_addr;
   logic [7:0] rd_data;

   modport master (
      input  rx,
      input  rd_addr,
      output char_valid,
      output char_data,
      output frame_err,
      output word_done,
      output word_len,
      output busy,
      output rd_data
   );

   modport slave (
      output rx,
      output rd_addr,
      input  char_valid,
      input  char_data,
      input  frame_err,
      input  word_done,
      input  word_len,
      input  busy,
      input  rd_data
   );
endinterface

// File: rtl/wordboard_rx.sv
// 8N1 receiver for the wordboard link that gathers characters into a word buffer.
// Define WBRX_TERM_EN to close words on TERM_CHAR, which is then not stored.
module wordboard_rx #(
   parameter int         CLKS_PER_BIT = 10417,
   parameter int         MAX_LEN      = 36,
   parameter int         IDLE_CLKS    = 312420,
   parameter logic [7:0] TERM_CHAR    = 8'h0D
) (
   input logic             sysclk,
   input logic             rst_n,
   wordboard_rx_if.master  bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TMR_W = (IDLE_CLKS > 2) ? $clog2(IDLE_CLKS) : 1;
   localparam int AW    = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

`ifdef WBRX_TERM_EN
   localparam bit TERM_EN = 1'b1;
`else
   localparam bit TERM_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             rx_meta;
   logic             rx_s;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic [5:0]       wptr;
   logic [TMR_W-1:0] idle_cnt;
   logic [7:0]       buffer [MAX_LEN];

   logic             half_tick;
   logic             full_tick;
   logic             busy_c;
   logic             shift_en;
   logic             good_char;
   logic             bad_stop;
   logic             is_term;
   logic             store;
   logic             full_close;
   logic             term_close;
   logic             timeout;

   // The line is asynchronous; nothing downstream looks at rx directly.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   assign half_tick = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
   assign full_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (!rx_s) state_next = S_START;
         end
         S_START: begin
            if (half_tick) state_next = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (full_tick && bit_idx == 3'd7) state_next = S_STOP;
         end
         S_STOP: begin
            if (full_tick) state_next = rx_s ? S_IDLE : S_BREAK;
         end
         S_BREAK: begin
            if (rx_s) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy_c    = 1'b0;
      shift_en  = 1'b0;
      good_char = 1'b0;
      bad_stop  = 1'b0;
      unique case (state)
         S_START: busy_c = 1'b1;
         S_DATA: begin
            busy_c   = 1'b1;
            shift_en = full_tick;
         end
         S_STOP: begin
            busy_c    = 1'b1;
            good_char = full_tick && rx_s;
            bad_stop  = full_tick && !rx_s;
         end
         default: begin
            busy_c = 1'b0;
         end
      endcase
   end

   assign bus.busy = busy_c;

   // The bit counter restarts on every state change and after each full bit.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         if (state_next != state || state == S_IDLE || state == S_BREAK || full_tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (state != S_DATA) begin
            bit_idx <= 3'd0;
         end else if (full_tick) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (shift_en) begin
            shreg <= {rx_s, shreg[7:1]};
         end
      end
   end

   assign is_term    = TERM_EN && (shreg == TERM_CHAR);
   assign store      = good_char && !is_term;
   assign full_close = store && (wptr == 6'(MAX_LEN - 1));
   assign term_close = good_char && is_term && (wptr != 6'd0);
   assign timeout    = (state == S_IDLE) && (wptr != 6'd0) &&
                       (idle_cnt == TMR_W'(IDLE_CLKS - 1));

   // A full buffer wins over the other closes, so a word is reported only once.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         bus.char_valid <= 1'b0;
         bus.char_data  <= 8'h00;
         bus.frame_err  <= 1'b0;
         bus.word_done  <= 1'b0;
         bus.word_len   <= 6'd0;
         wptr           <= 6'd0;
      end else begin
         bus.char_valid <= good_char;
         bus.frame_err  <= bad_stop;
         bus.word_done  <= full_close || term_close || timeout;
         if (good_char) begin
            bus.char_data <= shreg;
         end
         if (full_close) begin
            bus.word_len <= 6'(MAX_LEN);
            wptr         <= 6'd0;
         end else if (store) begin
            wptr <= wptr + 6'd1;
         end else if (term_close || timeout) begin
            bus.word_len <= wptr;
            wptr         <= 6'd0;
         end
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (good_char || bad_stop || state != S_IDLE || timeout) begin
         idle_cnt <= '0;
      end else if (wptr != 6'd0) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // Plain memory, not reset; a same-address read during a write sees old data.
   always_ff @(posedge sysclk) begin
      if (store) begin
         buffer[wptr[AW-1:0]] <= shreg;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data <= 8'h00;
      end else if (bus.rd_addr < 6'(MAX_LEN)) begin
         bus.rd_data <= buffer[bus.rd_addr[AW-1:0]];
      end else begin
         bus.rd_data <= 8'h00;
      end
   end

endmodule

// File: tb/tb_wordboard_rx.sv
// Directed bench for wordboard_rx: table of single frames plus hand-written
// sequences for words, full buffer, framing errors, glitches, reset and terminator.
module tb_wordboard_rx;

   localparam int CPB  = 16;
   localparam int IDLE = 200;
   localparam int MLEN = 36;

   logic sysclk = 1'b0;
   logic rst_n  = 1'b1;

   wordboard_rx_if bus ();

   wordboard_rx #(
      .CLKS_PER_BIT (CPB),
      .MAX_LEN      (MLEN),
      .IDLE_CLKS    (IDLE),
      .TERM_CHAR    (8'h0D)
   ) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   // Pulse counters sampled mid-cycle; tests look at differences from a mark.
   int cv_total = 0, fe_total = 0, wd_total = 0, busy_total = 0, last_cv = -1;
   always @(negedge sysclk) begin
      if (bus.char_valid) begin
         cv_total++;
         last_cv = cyc;
      end
      if (bus.frame_err) fe_total++;
      if (bus.word_done) wd_total++;
      if (bus.busy) busy_total++;
   end

   int cv_base, fe_base, wd_base, busy_base, frame_start;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_cv;
      int         exp_fe;
      int         exp_wd;
      int         exp_char;
      int         exp_len;
   } vec_t;

   vec_t vecs [6];

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
      end
   endtask

   task automatic mark();
      cv_base   = cv_total;
      fe_base   = fe_total;
      wd_base   = wd_total;
      busy_base = busy_total;
   endtask

   task automatic idle(input int n);
      bus.rx = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.rx      = 1'b1;
      bus.rd_addr = 6'd0;
      repeat (3) @(negedge sysclk);
      rst_n = 1'b1;
      @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop);
      bus.rx      = 1'b0;
      frame_start = cyc;
      repeat (CPB) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = data[i];
         repeat (CPB) @(negedge sysclk);
      end
      bus.rx = stop;
      repeat (CPB) @(negedge sysclk);
   endtask

   task automatic read_buf(input logic [5:0] a, output int v);
      bus.rd_addr = a;
      @(negedge sysclk);
      v = int'(bus.rd_data);
   endtask

   task automatic apply_stimulus(input vec_t v);
      int rd;
      do_reset();
      idle(10);
      mark();
      send_frame(v.data, v.stop);
      idle(250);
      check_output("vec char_valid count", cv_total - cv_base, v.exp_cv);
      check_output("vec frame_err count", fe_total - fe_base, v.exp_fe);
      check_output("vec word_done count", wd_total - wd_base, v.exp_wd);
      check_output("vec char_data", int'(bus.char_data), v.exp_char);
      check_output("vec word_len", int'(bus.word_len), v.exp_len);
      if (v.exp_len == 1) begin
         read_buf(6'd0, rd);
         check_output("vec rd_data[0]", rd, int'(v.data));
      end
   endtask

   initial begin
      logic [7:0] hello [5];
      int         rd;

      vecs[0] = '{8'h48, 1'b1, 1, 0, 1, 'h48, 1};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 1, 'h00, 1};
      vecs[2] = '{8'hFF, 1'b1, 1, 0, 1, 'hFF, 1};
      vecs[3] = '{8'hA5, 1'b1, 1, 0, 1, 'hA5, 1};
      vecs[4] = '{8'h5A, 1'b0, 0, 1, 0, 'h00, 0};
`ifdef WBRX_TERM_EN
      vecs[5] = '{8'h0D, 1'b1, 1, 0, 0, 'h0D, 0};
`else
      vecs[5] = '{8'h0D, 1'b1, 1, 0, 1, 'h0D, 1};
`endif
      hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

      bus.rx      = 1'b1;
      bus.rd_addr = 6'd0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge sysclk);
      check_output("reset char_valid", int'(bus.char_valid), 0);
      check_output("reset char_data", int'(bus.char_data), 0);
      check_output("reset frame_err", int'(bus.frame_err), 0);
      check_output("reset word_done", int'(bus.word_done), 0);
      check_output("reset word_len", int'(bus.word_len), 0);
      check_output("reset busy", int'(bus.busy), 0);
      check_output("reset rd_data", int'(bus.rd_data), 0);
      rst_n = 1'b1;
      idle(10);

      // Latency of a single frame from the start edge to char_valid.
      mark();
      send_frame(8'h48, 1'b1);
      idle(10);
      check_output("latency", last_cv - frame_start, 2 + CPB / 2 + 9 * CPB + 1);
      check_output("latency char_valid count", cv_total - cv_base, 1);
      check_output("latency char_data", int'(bus.char_data), 'h48);

      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i]);
      end

      // HELLO back-to-back, closed by the idle timeout.
      do_reset();
      idle(10);
      mark();
      for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1);
      check_output("hello no early word_done", wd_total - wd_base, 0);
      idle(250);
      check_output("hello char_valid count", cv_total - cv_base, 5);
      check_output("hello word_done count", wd_total - wd_base, 1);
      check_output("hello word_len", int'(bus.word_len), 5);
      for (int i = 0; i < 5; i++) begin
         read_buf(6'(i), rd);
         check_output("hello rd_data", rd, int'(hello[i]));
      end
      read_buf(6'd40, rd);
      check_output("rd_data out of range", rd, 0);

      // 40 frames: buffer fills at 36, the rest start a new word.
      do_reset();
      idle(10);
      mark();
      for (int i = 0; i < 36; i++) send_frame(8'h30 + 8'(i), 1'b1);
      check_output("full word_done count", wd_total - wd_base, 1);
      check_output("full word_len", int'(bus.word_len), 36);
      for (int i = 36; i < 40; i++) send_frame(8'h30 + 8'(i), 1'b1);
      read_buf(6'd0, rd);
      check_output("full 37th char at addr 0", rd, 'h54);
      read_buf(6'd3, rd);
      check_output("full 40th char at addr 3", rd, 'h57);
      read_buf(6'd4, rd);
      check_output("full old data persists", rd, 'h34);
      idle(250);
      check_output("full word_done total", wd_total - wd_base, 2);
      check_output("full second word_len", int'(bus.word_len), 4);

      // Bad stop bit with line held low, then recovery.
      do_reset();
      idle(10);
      mark();
      send_frame(8'h30, 1'b1);
      send_frame(8'h41, 1'b0);
      repeat (100) @(negedge sysclk);
      check_output("break frame_err count", fe_total - fe_base, 1);
      check_output("break char_valid count", cv_total - cv_base, 1);
      idle(20);
      check_output("break busy after", int'(bus.busy), 0);
      send_frame(8'h42, 1'b1);
      idle(250);
      check_output("break frame_err total", fe_total - fe_base, 1);
      check_output("break char_valid total", cv_total - cv_base, 2);
      check_output("break char_data", int'(bus.char_data), 'h42);
      check_output("break word_done", wd_total - wd_base, 1);
      check_output("break word_len", int'(bus.word_len), 2);
      read_buf(6'd0, rd);
      check_output("break rd_data[0]", rd, 'h30);
      read_buf(6'd1, rd);
      check_output("break rd_data[1]", rd, 'h42);

      // Short low glitch on an idle line.
      do_reset();
      idle(20);
      mark();
      bus.rx = 1'b0;
      repeat (5) @(negedge sysclk);
      idle(40);
      check_output("glitch busy seen", int'((busy_total - busy_base) > 0), 1);
      check_output("glitch busy now", int'(bus.busy), 0);
      check_output("glitch pulses", (cv_total - cv_base) + (fe_total - fe_base) +
                   (wd_total - wd_base), 0);

      // Reset in the middle of a data bit with a partial word pending.
      do_reset();
      idle(10);
      send_frame(8'h51, 1'b1);
      bus.rx = 1'b0;
      repeat (CPB) @(negedge sysclk);
      bus.rx = 1'b1;
      repeat (CPB) @(negedge sysclk);
      bus.rx = 1'b0;
      repeat (CPB) @(negedge sysclk);
      check_output("midreset busy before", int'(bus.busy), 1);
      rst_n = 1'b0;
      repeat (2) @(negedge sysclk);
      check_output("midreset char_data", int'(bus.char_data), 0);
      check_output("midreset busy", int'(bus.busy), 0);
      check_output("midreset char_valid", int'(bus.char_valid), 0);
      bus.rx = 1'b1;
      rst_n  = 1'b1;
      mark();
      idle(300);
      check_output("midreset pulses after", (cv_total - cv_base) + (fe_total - fe_base) +
                   (wd_total - wd_base), 0);
      check_output("midreset word_len", int'(bus.word_len), 0);

      // "AB" followed by the terminator code.
      do_reset();
      idle(10);
      mark();
      send_frame(8'h41, 1'b1);
      send_frame(8'h42, 1'b1);
      send_frame(8'h0D, 1'b1);
      idle(5);
`ifdef WBRX_TERM_EN
      check_output("term word_done at terminator", wd_total - wd_base, 1);
      check_output("term word_len", int'(bus.word_len), 2);
      idle(250);
      check_output("term word_done total", wd_total - wd_base, 1);
`else
      check_output("term no early word_done", wd_total - wd_base, 0);
      idle(250);
      check_output("term word_done total", wd_total - wd_base, 1);
      check_output("term word_len", int'(bus.word_len), 3);
      read_buf(6'd2, rd);
      check_output("term stored as data", rd, 'h0D);
`endif
      check_output("term char_valid count", cv_total - cv_base, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wordboard_rx.md
Name: wordboard_rx

Overview:
- Serial receive end of the wordboard character link. Deserialises the 8N1 stream driven by the cereal transmitter (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit).
- Collects received characters into a word buffer and closes a word on a line-idle timeout or a full buffer.
- Exposes each character as it arrives, plus a readable buffer of the completed word, for display or loopback checking on the board.

Parameters:
- CLKS_PER_BIT, 10417, sysclk cycles per bit period (100 MHz / 9600 baud)
- MAX_LEN, 36, word buffer depth in characters (longest wordboard word); must be <= 63
- IDLE_CLKS, 312420, idle-high sysclk cycles after the last stop bit that close a word
- TERM_CHAR, 8'h0D, terminator code, used only with WBRX_TERM_EN

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial line, asynchronous to sysclk
- char_valid  out  1  one-cycle pulse: char_data holds a good character
- char_data  out  8  last good character, held until next one
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- word_done  out  1  one-cycle pulse: word closed, word_len updated
- word_len  out  6  character count of last closed word, held
- busy  out  1  high while a frame is in progress (START/DATA/STOP)
- rd_addr  in  6  word buffer read address
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency; 0 if rd_addr >= MAX_LEN

Behaviour:
- Clocking and reset:
  - One clock (sysclk); reset is asynchronous, active-low (rst_n).
  - Reset values: all outputs 0, state IDLE, write pointer 0, idle timer 0, rx synchroniser 1.
  - Reset mid-frame or mid-word drops the partial character and word; no pulses are emitted.
- Input: rx passes through a 2-FF synchroniser (rx_s). All decisions use rx_s only.
- Receive FSM (bit counter counts to CLKS_PER_BIT-1):
  - IDLE: rx_s==0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1, rx_s==0 -> DATA, counter cleared; rx_s==1 is a glitch -> IDLE, no pulse.
  - DATA: at count CLKS_PER_BIT-1, shift rx_s in at the MSB (LSB-first); after the 8th bit -> STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: pulse char_valid next cycle, load char_data, write the buffer, go to IDLE.
    - rx_s==0: pulse frame_err, discard the character, go to BREAK.
  - BREAK: wait for rx_s==1, then IDLE. A held-low line produces exactly one frame_err.
- Latency: char_valid rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge.
- Word buffer:
  - On a good character: buffer[wptr] <= char; wptr increments.
  - If wptr reaches MAX_LEN: word_done next cycle, word_len <= MAX_LEN, wptr <= 0.
- Idle timer:
  - Cleared on any good character or frame_err, and whenever state != IDLE.
  - Counts in IDLE only while wptr != 0.
  - At IDLE_CLKS-1: word_done, word_len <= wptr, wptr <= 0, timer cleared.
  - The timer never fires with wptr==0, so there are no empty words.
- Buffer reads:
  - Contents persist after word_done; the next word's first character overwrites address 0.
  - The reader must finish reading before the next word starts.
  - A read and a write to the same address in the same cycle return the old data.
- Coincident events: a good character fills the buffer and a word_done is due in the same cycle -> one word_done only. frame_err never changes wptr.

Optional Feature:
- Macro: WBRX_TERM_EN.
- When defined: a good character equal to TERM_CHAR is not stored and closes the word. word_done fires next cycle with word_len = wptr; if wptr==0, nothing happens. char_valid still pulses for the terminator.
- When undefined: TERM_CHAR is stored as ordinary data; words close only on timeout or full buffer.

Test Plan (CLKS_PER_BIT=16, IDLE_CLKS=200, MAX_LEN=36):
- Reset, then one frame 0x48 -> char_valid once, 2+8+144+1=155 cycles after the start edge, char_data=0x48; frame_err=0.
- Frames "HELLO" back-to-back, then rx high 200 cycles -> 5 char_valid, word_done once, word_len=5, rd_addr 0..4 reads 48 45 4C 4C 4F.
- 40 consecutive frames -> word_done after the 36th with word_len=36; the 37th character lands at address 0; timeout later gives word_len=4.
- Frame 0x41 with stop bit low, line then held low 100 cycles -> one frame_err, no char_valid, wptr unchanged; recovers and receives 0x42 correctly.
- 5-cycle low glitch on idle rx -> no pulses, busy returns to 0. rst_n low mid-DATA -> outputs 0, no word_done afterwards.
- WBRX_TERM_EN: "AB" + 0x0D -> 3 char_valid, word_done after the terminator with word_len=2. Without the macro, the same stimulus gives word_len=3 after the timeout.
